wb_gpio_slave: RTL and testbench

WB_GPIO_SLAVE -- requirements
Module: wb_gpio_slave

---
 rtl/wb_gpio_slave_pkg.sv | 30 +++
 rtl/wb_gpio_slave_if.sv | 31 +++
 rtl/wb_gpio_slave_gpio_sync.sv | 49 ++++
 rtl/wb_gpio_slave.sv | 161 ++++++++++++++++
 tb/tb_wb_gpio_slave.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gpio_slave_pkg.sv
// Shared constants for the Wishbone GPIO slave: bus widths, register offsets, slave select, ack FSM encoding.
// Optional edge-interrupt logic is enabled by defining the GPIO_IRQ_EN macro.
`ifndef WB_AD_WIDTH
`define WB_AD_WIDTH 32
`endif
`ifndef WB_DAT_WIDTH
`define WB_DAT_WIDTH 32
`endif

package wb_gpio_slave_pkg;

    localparam int WB_AW = `WB_AD_WIDTH;
    localparam int WB_DW = `WB_DAT_WIDTH;
    localparam int WB_SW = WB_DW / 8;

    localparam logic [3:0] GPIO_SLAVE_SEL = 4'h2;

    // Word offsets decoded from addr[4:2]
    localparam logic [2:0] GPIO_DATA_IN  = 3'd0;
    localparam logic [2:0] GPIO_DATA_OUT = 3'd1;
    localparam logic [2:0] GPIO_DIR      = 3'd2;
    localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
    localparam logic [2:0] GPIO_IRQ_PEND = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

endpackage

// File: rtl/wb_gpio_slave_if.sv
// Wishbone slave-side bus bundle for the GPIO block; the master drives requests, the slave returns ack/data.
`ifndef WB_AD_WIDTH
`define WB_AD_WIDTH 32
`endif
`ifndef WB_DAT_WIDTH
`define WB_DAT_WIDTH 32
`endif

interface wb_gpio_slave_if;
    import wb_gpio_slave_pkg::*;

    logic             wbs_cyc_i;
    logic             wbs_stb_i;
    logic             wbs_we_i;
    logic [WB_AW-1:0] wbs_addr_i;
    logic [WB_DW-1:0] wbs_wdata_i;
    logic [WB_SW-1:0] wbs_sel_i;
    logic [WB_DW-1:0] wbs_rdata_o;
    logic             wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        input  wbs_rdata_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_addr_i, wbs_wdata_i, wbs_sel_i,
        output wbs_rdata_o, wbs_ack_o
    );

endinterface

// File: rtl/wb_gpio_slave_gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, plus a rising-edge detector when GPIO_IRQ_EN is defined.
module gpio_sync #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
`ifdef GPIO_IRQ_EN
    output logic [W-1:0] rise,
`endif
    output logic [W-1:0] sync
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= din[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync[gi] = sync_reg;

`ifdef GPIO_IRQ_EN
            // Third flop remembers the previous synchronized level for edge detection
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= sync_reg;
                end
            end

            assign rise[gi] = sync_reg & ~prev_reg;
`endif
        end
    endgenerate

endmodule

// File: rtl/wb_gpio_slave.sv
// Wishbone GPIO slave: DATA_IN/DATA_OUT/DIR registers with single-cycle ack; edge interrupts
// (IRQ_EN/IRQ_PEND, gpio_irq_o) exist only when the GPIO_IRQ_EN macro is defined.
module wb_gpio_slave
    import wb_gpio_slave_pkg::*;
#(
    parameter int         GPIO_W   = 16,
    parameter logic [3:0] BASE_SEL = GPIO_SLAVE_SEL
) (
    input  logic              clk,
    input  logic              rst,
    wb_gpio_slave_if.slave    wbs,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              gpio_irq_o
);

    ack_state_t        state_reg;
    logic              ack_reg;
    logic [WB_DW-1:0]  rdata_reg;
    logic [GPIO_W-1:0] data_out_reg;
    logic [GPIO_W-1:0] dir_reg;
    logic [GPIO_W-1:0] data_in;

    logic              accept;
    logic              wr_en;
    logic [2:0]        reg_idx;
    logic [WB_DW-1:0]  lane_mask;
    logic [WB_DW-1:0]  rd_val;
    logic [WB_DW-1:0]  wr_val;

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] irq_en_reg;
    logic [GPIO_W-1:0] irq_pend_reg;
    logic [GPIO_W-1:0] w1c_bits;
    logic [WB_DW-1:0]  w1c_full;
    logic              irq_reg;
`endif

    gpio_sync #(
        .W (GPIO_W)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_in_i),
`ifdef GPIO_IRQ_EN
        .rise (rise),
`endif
        .sync (data_in)
    );

    // The bus is broadcast; holding off while ack is high guarantees no back-to-back acks
    assign accept  = wbs.wbs_cyc_i && wbs.wbs_stb_i &&
                     (wbs.wbs_addr_i[11:8] == BASE_SEL) &&
                     !ack_reg && (state_reg == ST_IDLE);
    assign wr_en   = accept && wbs.wbs_we_i;
    assign reg_idx = wbs.wbs_addr_i[4:2];

    genvar gi;
    generate
        for (gi = 0; gi < WB_SW; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wbs.wbs_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            GPIO_DATA_IN:  rd_val[GPIO_W-1:0] = data_in;
            GPIO_DATA_OUT: rd_val[GPIO_W-1:0] = data_out_reg;
            GPIO_DIR:      rd_val[GPIO_W-1:0] = dir_reg;
`ifdef GPIO_IRQ_EN
            GPIO_IRQ_EN:   rd_val[GPIO_W-1:0] = irq_en_reg;
            GPIO_IRQ_PEND: rd_val[GPIO_W-1:0] = irq_pend_reg;
`endif
            default:       rd_val = '0;
        endcase
    end

    // Merge enabled byte lanes of the write data into the current register value
    assign wr_val = (rd_val & ~lane_mask) | (wbs.wbs_wdata_i & lane_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
                        rdata_reg <= rd_val;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg <= '0;
            dir_reg      <= '0;
        end else if (wr_en) begin
            case (reg_idx)
                GPIO_DATA_OUT: data_out_reg <= wr_val[GPIO_W-1:0];
                GPIO_DIR:      dir_reg      <= wr_val[GPIO_W-1:0];
                default:       ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    assign w1c_full = wbs.wbs_wdata_i & lane_mask;
    assign w1c_bits = (wr_en && (reg_idx == GPIO_IRQ_PEND)) ? w1c_full[GPIO_W-1:0] : '0;

    // The set term is ORed after the clear so a coincident new edge survives W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_reg   <= '0;
            irq_pend_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_en && (reg_idx == GPIO_IRQ_EN)) begin
                irq_en_reg <= wr_val[GPIO_W-1:0];
            end
            irq_pend_reg <= (irq_pend_reg & ~w1c_bits) | (rise & irq_en_reg);
            irq_reg      <= |(irq_pend_reg & irq_en_reg);
        end
    end

    assign gpio_irq_o = irq_reg;

    logic unused_irq_bits;
    assign unused_irq_bits = ^w1c_full;
`else
    assign gpio_irq_o = 1'b0;
`endif

    assign wbs.wbs_ack_o   = ack_reg;
    assign wbs.wbs_rdata_o = rdata_reg;
    assign gpio_out_o      = data_out_reg;
    assign gpio_oe_o       = dir_reg;

    // Address bits outside the decode and register bits above GPIO_W are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_addr_i, wr_val};

endmodule

// File: tb/tb_wb_gpio_slave.sv
// Directed bench for wb_gpio_slave: register table plus hand sequences for sync latency, back-to-back
// requests, reset during ack and (when GPIO_IRQ_EN is defined) edge interrupts.
`timescale 1ns/1ps
module tb_wb_gpio_slave;

    logic        clk;
    logic        rst;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        gpio_irq;

    int n_pass  = 0;
    int n_total = 0;

    wb_gpio_slave_if wbs ();

    wb_gpio_slave #(
        .GPIO_W   (16),
        .BASE_SEL (4'h2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbs        (wbs),
        .gpio_in_i  (gpio_in),
        .gpio_out_o (gpio_out),
        .gpio_oe_o  (gpio_oe),
        .gpio_irq_o (gpio_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input logic chk_rd, input logic [31:0] exp_rd,
                                input int exp_lat, input logic [15:0] exp_out, input logic [15:0] exp_oe);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.chk_rd = chk_rd;
        v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_out = exp_out; v.exp_oe = exp_oe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transfer; lat is the number of edges until ack (0 = no ack within 4 cycles)
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, output logic [31:0] rd, output int lat);
        @(negedge clk);
        wbs.wbs_cyc_i   = 1'b1;
        wbs.wbs_stb_i   = 1'b1;
        wbs.wbs_we_i    = we;
        wbs.wbs_addr_i  = addr;
        wbs.wbs_wdata_i = wdata;
        wbs.wbs_sel_i   = sel;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (wbs.wbs_ack_o) begin
                lat = i;
                rd  = wbs.wbs_rdata_o;
                break;
            end
        end
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        $display("bus we=%0b addr=0x%03h wdata=0x%08h sel=%b -> lat=%0d rdata=0x%08h",
                 we, addr[11:0], wdata, sel, lat, rd);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;

        rst = 1'b1;
        gpio_in = 16'h0000;
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        wbs.wbs_addr_i = '0; wbs.wbs_wdata_i = '0; wbs.wbs_sel_i = '0;

        vecs[0]  = mk(1'b1, 32'h208, 32'h0000_00FF, 4'hF, 1'b0, 32'h0,        1, 16'h0000, 16'h00FF);
        vecs[1]  = mk(1'b1, 32'h204, 32'h0000_00A5, 4'hF, 1'b0, 32'h0,        1, 16'h00A5, 16'h00FF);
        vecs[2]  = mk(1'b0, 32'h208, 32'h0,         4'hF, 1'b1, 32'h0000_00FF, 1, 16'h00A5, 16'h00FF);
        vecs[3]  = mk(1'b0, 32'h204, 32'h0,         4'hF, 1'b1, 32'h0000_00A5, 1, 16'h00A5, 16'h00FF);
        vecs[4]  = mk(1'b1, 32'h204, 32'h0,         4'hF, 1'b0, 32'h0,        1, 16'h0000, 16'h00FF);
        vecs[5]  = mk(1'b1, 32'h204, 32'h0000_FFFF, 4'h1, 1'b0, 32'h0,        1, 16'h00FF, 16'h00FF);
        vecs[6]  = mk(1'b0, 32'h204, 32'h0,         4'hF, 1'b1, 32'h0000_00FF, 1, 16'h00FF, 16'h00FF);
        vecs[7]  = mk(1'b1, 32'h204, 32'h1234_5678, 4'h2, 1'b0, 32'h0,        1, 16'h56FF, 16'h00FF);
        vecs[8]  = mk(1'b0, 32'h204, 32'h0,         4'hF, 1'b1, 32'h0000_56FF, 1, 16'h56FF, 16'h00FF);
        vecs[9]  = mk(1'b1, 32'h204, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,        1, 16'hFFFF, 16'h00FF);
        vecs[10] = mk(1'b0, 32'h204, 32'h0,         4'hF, 1'b1, 32'h0000_FFFF, 1, 16'hFFFF, 16'h00FF);
        vecs[11] = mk(1'b1, 32'h214, 32'h0000_FFFF, 4'hF, 1'b0, 32'h0,        1, 16'hFFFF, 16'h00FF);
        vecs[12] = mk(1'b0, 32'h214, 32'h0,         4'hF, 1'b1, 32'h0,        1, 16'hFFFF, 16'h00FF);
        vecs[13] = mk(1'b1, 32'h304, 32'h0,         4'hF, 1'b0, 32'h0,        0, 16'hFFFF, 16'h00FF);
        vecs[14] = mk(1'b0, 32'h308, 32'h0,         4'hF, 1'b0, 32'h0,        0, 16'hFFFF, 16'h00FF);
        vecs[15] = mk(1'b1, 32'h200, 32'h0,         4'hF, 1'b0, 32'h0,        1, 16'hFFFF, 16'h00FF);
        vecs[16] = mk(1'b0, 32'h200, 32'h0,         4'hF, 1'b1, 32'h0,        1, 16'hFFFF, 16'h00FF);
        vecs[17] = mk(1'b1, 32'h208, 32'h0000_FF00, 4'h2, 1'b0, 32'h0,        1, 16'hFFFF, 16'hFFFF);
        vecs[18] = mk(1'b1, 32'h208, 32'h0,         4'h1, 1'b0, 32'h0,        1, 16'hFFFF, 16'hFF00);
        vecs[19] = mk(1'b0, 32'h208, 32'h0,         4'hF, 1'b1, 32'h0000_FF00, 1, 16'hFFFF, 16'hFF00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ack",   {31'h0, wbs.wbs_ack_o}, 32'h0);
        check("reset_rdata", wbs.wbs_rdata_o, 32'h0);
        check("reset_out",   {16'h0, gpio_out}, 32'h0);
        check("reset_oe",    {16'h0, gpio_oe}, 32'h0);
        check("reset_irq",   {31'h0, gpio_irq}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_out", i), {16'h0, gpio_out}, {16'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_oe", i),  {16'h0, gpio_oe},  {16'h0, vecs[i].exp_oe});
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Synchronizer latency: an immediate read still sees the old value
        @(negedge clk);
        gpio_in = 16'h1234;
        bus(1'b0, 32'h200, 32'h0, 4'hF, rd, lat);
        check("din_early", rd, 32'h0);
        bus(1'b0, 32'h200, 32'h0, 4'hF, rd, lat);
        check("din_late", rd, 32'h0000_1234);

        // Request held continuously: ack toggles, rdata zero whenever ack is low
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
        wbs.wbs_addr_i = 32'h208; wbs.wbs_sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_ack%0d", i), {31'h0, wbs.wbs_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("b2b_rdata%0d", i), wbs.wbs_rdata_o, (i % 2 == 0) ? 32'h0000_FF00 : 32'h0);
        end
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        $display("seq back-to-back done");

        // cyc dropped during ACK: ack still lasts exactly one cycle
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_addr_i = 32'h204;
        @(posedge clk); #1;
        check("drop_ack_hi", {31'h0, wbs.wbs_ack_o}, 32'h1);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        check("drop_ack_lo", {31'h0, wbs.wbs_ack_o}, 32'h0);
        $display("seq cyc-drop done");

`ifdef GPIO_IRQ_EN
        bus(1'b1, 32'h20C, 32'h0000_0001, 4'hF, rd, lat);
        bus(1'b0, 32'h20C, 32'h0, 4'hF, rd, lat);
        check("irqen_rd", rd, 32'h0000_0001);
        @(negedge clk);
        gpio_in = 16'h1235;
        repeat (5) @(posedge clk); #1;
        check("irq_set", {31'h0, gpio_irq}, 32'h1);
        bus(1'b0, 32'h210, 32'h0, 4'hF, rd, lat);
        check("pend_set", rd, 32'h0000_0001);
        @(negedge clk);
        gpio_in = 16'h1234;
        repeat (4) @(negedge clk);
        gpio_in = 16'h1235;
        repeat (2) @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
        wbs.wbs_addr_i = 32'h210; wbs.wbs_wdata_i = 32'h1; wbs.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("w1c_edge_ack", {31'h0, wbs.wbs_ack_o}, 32'h1);
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("w1c_edge_irq", {31'h0, gpio_irq}, 32'h1);
        bus(1'b0, 32'h210, 32'h0, 4'hF, rd, lat);
        check("w1c_edge_pend", rd, 32'h0000_0001);
        bus(1'b1, 32'h210, 32'h0000_0001, 4'hF, rd, lat);
        repeat (2) @(posedge clk); #1;
        check("w1c_irq", {31'h0, gpio_irq}, 32'h0);
        bus(1'b0, 32'h210, 32'h0, 4'hF, rd, lat);
        check("w1c_pend", rd, 32'h0);
`else
        bus(1'b1, 32'h20C, 32'h0000_FFFF, 4'hF, rd, lat);
        check("noirq_en_lat", lat, 1);
        bus(1'b0, 32'h20C, 32'h0, 4'hF, rd, lat);
        check("noirq_en_rd", rd, 32'h0);
        @(negedge clk);
        gpio_in = 16'hFFFF;
        repeat (5) @(posedge clk); #1;
        check("noirq_irq", {31'h0, gpio_irq}, 32'h0);
        bus(1'b0, 32'h210, 32'h0, 4'hF, rd, lat);
        check("noirq_pend_rd", rd, 32'h0);
`endif
        $display("seq irq done");

        // Reset during ACK: the write committed on the accept edge, then everything clears
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
        wbs.wbs_addr_i = 32'h204; wbs.wbs_wdata_i = 32'h0F0F; wbs.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("rst_ack_hi", {31'h0, wbs.wbs_ack_o}, 32'h1);
        check("rst_commit", {16'h0, gpio_out}, 32'h0000_0F0F);
        rst = 1'b1;
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        @(posedge clk); #1;
        check("rst_ack_lo", {31'h0, wbs.wbs_ack_o}, 32'h0);
        check("rst_rdata",  wbs.wbs_rdata_o, 32'h0);
        check("rst_out",    {16'h0, gpio_out}, 32'h0);
        check("rst_oe",     {16'h0, gpio_oe}, 32'h0);
        check("rst_irq",    {31'h0, gpio_irq}, 32'h0);

        // Request coincident with reset: reset wins on that edge, nothing is written or acked
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
        wbs.wbs_addr_i = 32'h204; wbs.wbs_wdata_i = 32'hAAAA; wbs.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        check("rst_req_ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        check("rst_req_out", {16'h0, gpio_out}, 32'h0);
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("seq reset done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
